spad_fill_ctrl: RTL and testbench

//  Producer-side controller for a PE scratchpad (RF instance, registered read, 1-cycle latency).

---
 rtl/spad_fill_ctrl.sv | 96 +++++++++
 tb/tb_spad_fill_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/spad_fill_ctrl.sv
// Producer-side scratchpad controller: writes an incoming element stream into an RF used as a
// circular buffer, serves windowed reads relative to the oldest entry, and releases entries on pop.
module spad_fill_ctrl #(
   parameter int WIDTH      = 4,
   parameter int SIZE       = 4,
   parameter int ADDR_WIDTH = $clog2(SIZE)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [WIDTH-1:0]      in_data,
   output logic                  in_ready,
   input  logic                  rd_req,
   input  logic [ADDR_WIDTH-1:0] rd_offset,
   input  logic                  pop,
   output logic                  out_valid,
   output logic [WIDTH-1:0]      out_data,
   output logic                  rd_err,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  rf_wen,
   output logic [ADDR_WIDTH-1:0] rf_waddr,
   output logic [WIDTH-1:0]      rf_din,
   output logic                  rf_ren,
   output logic [ADDR_WIDTH-1:0] rf_raddr,
   input  logic [WIDTH-1:0]      rf_dout
);

   localparam logic [ADDR_WIDTH:0]   SIZE_C = (ADDR_WIDTH+1)'(SIZE);
   localparam logic [ADDR_WIDTH-1:0] LAST_C = ADDR_WIDTH'(SIZE - 1);

   logic [ADDR_WIDTH-1:0] wr_ptr_reg, wr_ptr_next;
   logic [ADDR_WIDTH-1:0] head_reg, head_next;
   logic [ADDR_WIDTH:0]   count_reg, count_next;
   logic                  out_valid_reg, out_valid_next;
   logic                  rd_err_reg, rd_err_next;

   logic                  push;
   logic                  pop_eff;
   logic                  rd_ok;
   logic [ADDR_WIDTH:0]   rd_sum;
   logic [ADDR_WIDTH:0]   rd_wrapped;

   always_comb begin
      in_ready = !rst && (count_reg < SIZE_C);
      push     = in_valid && in_ready;
      pop_eff  = pop && (count_reg != '0);
      // Range check uses the pre-edge count, so an entry being written this cycle is not readable.
      rd_ok    = rd_req && ({1'b0, rd_offset} < count_reg);

      // head < SIZE and offset < SIZE, so one conditional subtract is enough for any SIZE.
      rd_sum     = {1'b0, head_reg} + {1'b0, rd_offset};
      rd_wrapped = (rd_sum >= SIZE_C) ? (rd_sum - SIZE_C) : rd_sum;

      rf_wen   = push;
      rf_waddr = wr_ptr_reg;
      rf_din   = in_data;
      rf_ren   = rd_ok;
      rf_raddr = rd_wrapped[ADDR_WIDTH-1:0];

      wr_ptr_next = wr_ptr_reg;
      if (push) begin
         wr_ptr_next = (wr_ptr_reg == LAST_C) ? '0 : wr_ptr_reg + ADDR_WIDTH'(1);
      end

      head_next = head_reg;
      if (pop_eff) begin
         head_next = (head_reg == LAST_C) ? '0 : head_reg + ADDR_WIDTH'(1);
      end

      count_next     = count_reg + (ADDR_WIDTH+1)'(push) - (ADDR_WIDTH+1)'(pop_eff);
      out_valid_next = rd_ok;
      rd_err_next    = rd_req && !rd_ok;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg    <= '0;
         head_reg      <= '0;
         count_reg     <= '0;
         out_valid_reg <= 1'b0;
         rd_err_reg    <= 1'b0;
      end else begin
         wr_ptr_reg    <= wr_ptr_next;
         head_reg      <= head_next;
         count_reg     <= count_next;
         out_valid_reg <= out_valid_next;
         rd_err_reg    <= rd_err_next;
      end
   end

   assign out_valid = out_valid_reg;
   assign out_data  = rf_dout;
   assign rd_err    = rd_err_reg;
   assign count     = count_reg;

endmodule

// File: tb/tb_spad_fill_ctrl.sv
// Directed bench for spad_fill_ctrl (SIZE=4, WIDTH=4) with a registered-read RF attached.
module tb_spad_fill_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [3:0] in_data;
   logic       in_ready;
   logic       rd_req;
   logic [1:0] rd_offset;
   logic       pop;
   logic       out_valid;
   logic [3:0] out_data;
   logic       rd_err;
   logic [2:0] count;
   logic       rf_wen;
   logic [1:0] rf_waddr;
   logic [3:0] rf_din;
   logic       rf_ren;
   logic [1:0] rf_raddr;
   logic [3:0] rf_dout;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   spad_fill_ctrl #(.WIDTH(4), .SIZE(4)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .rd_req(rd_req), .rd_offset(rd_offset), .pop(pop),
      .out_valid(out_valid), .out_data(out_data), .rd_err(rd_err), .count(count),
      .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_din(rf_din),
      .rf_ren(rf_ren), .rf_raddr(rf_raddr), .rf_dout(rf_dout)
   );

   // Scratchpad RF: synchronous write, registered read
   logic [3:0] rf_mem [4];
   always @(posedge clk) begin
      if (rf_wen) rf_mem[rf_waddr] <= rf_din;
      if (rf_ren) rf_dout <= rf_mem[rf_raddr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid = 1'b0; in_data = '0; rd_req = 1'b0; rd_offset = '0; pop = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      repeat (3) step();
      chk("reset_count", 32'(count), 32'd0);
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_rd_err", 32'(rd_err), 32'd0);
      chk("reset_in_ready", 32'(in_ready), 32'd0);

      rst = 1'b0;
      #1;
      chk("post_reset_in_ready", 32'(in_ready), 32'd1);

      // Fill with 1..4
      for (int k = 0; k < 4; k++) begin
         in_valid = 1'b1; in_data = 4'(k + 1);
         #1;
         chk("fill_wen", 32'(rf_wen), 32'd1);
         chk("fill_waddr", 32'(rf_waddr), 32'(k));
         chk("fill_din", 32'(rf_din), 32'(k + 1));
         step();
      end
      chk("full_count", 32'(count), 32'd4);
      chk("full_in_ready", 32'(in_ready), 32'd0);

      in_valid = 1'b1; in_data = 4'd5;
      #1;
      chk("full_push_wen", 32'(rf_wen), 32'd0);
      step();
      chk("full_push_count", 32'(count), 32'd4);
      idle();

      // Back-to-back windowed reads
      for (int k = 0; k < 4; k++) begin
         rd_req = 1'b1; rd_offset = 2'(k);
         #1;
         chk("rd_ren", 32'(rf_ren), 32'd1);
         chk("rd_raddr", 32'(rf_raddr), 32'(k));
         step();
         chk("rd_out_valid", 32'(out_valid), 32'd1);
         chk("rd_out_data", 32'(out_data), 32'(k + 1));
      end
      idle();
      step();
      chk("rd_idle_out_valid", 32'(out_valid), 32'd0);

      // Pop two, push 5,6 which wrap to addresses 0,1
      pop = 1'b1;
      step();
      step();
      pop = 1'b0;
      chk("pop2_count", 32'(count), 32'd2);
      for (int k = 0; k < 2; k++) begin
         in_valid = 1'b1; in_data = 4'(k + 5);
         #1;
         chk("wrap_waddr", 32'(rf_waddr), 32'(k));
         step();
      end
      idle();
      chk("wrap_count", 32'(count), 32'd4);

      rd_req = 1'b1; rd_offset = 2'd2;
      #1;
      chk("wrap_raddr_off2", 32'(rf_raddr), 32'd0);
      step();
      chk("wrap_data_off2", 32'(out_data), 32'd5);
      rd_offset = 2'd3;
      #1;
      chk("wrap_raddr_off3", 32'(rf_raddr), 32'd1);
      step();
      chk("wrap_data_off3", 32'(out_data), 32'd6);
      chk("wrap_valid_off3", 32'(out_valid), 32'd1);
      idle();

      // Out-of-range read at count=2 (head now 0, entries 5,6)
      pop = 1'b1;
      step();
      step();
      pop = 1'b0;
      chk("oor_count", 32'(count), 32'd2);
      rd_req = 1'b1; rd_offset = 2'd2;
      #1;
      chk("oor_ren", 32'(rf_ren), 32'd0);
      step();
      chk("oor_rd_err", 32'(rd_err), 32'd1);
      chk("oor_out_valid", 32'(out_valid), 32'd0);
      idle();
      step();
      chk("oor_rd_err_clear", 32'(rd_err), 32'd0);

      // Read + pop: offset 0 returns the entry being popped
      rd_req = 1'b1; rd_offset = 2'd0; pop = 1'b1;
      #1;
      chk("rdpop_raddr", 32'(rf_raddr), 32'd0);
      step();
      idle();
      chk("rdpop_data", 32'(out_data), 32'd5);
      chk("rdpop_count", 32'(count), 32'd1);

      // Refill: 7,8,9 at addresses 2,3,0 (head=1, entries 6,7,8,9)
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1; in_data = 4'(k + 7);
         step();
      end
      idle();
      chk("refill_count", 32'(count), 32'd4);

      // Full with pop+push: push refused, count drops
      in_valid = 1'b1; in_data = 4'hA; pop = 1'b1;
      #1;
      chk("fullpp_in_ready", 32'(in_ready), 32'd0);
      chk("fullpp_wen", 32'(rf_wen), 32'd0);
      step();
      idle();
      chk("fullpp_count", 32'(count), 32'd3);

      // Read + push: entry being written is out of range (count=3, offset 3)
      in_valid = 1'b1; in_data = 4'hB; rd_req = 1'b1; rd_offset = 2'd3;
      #1;
      chk("rdpush_waddr", 32'(rf_waddr), 32'd1);
      chk("rdpush_ren", 32'(rf_ren), 32'd0);
      step();
      idle();
      chk("rdpush_rd_err", 32'(rd_err), 32'd1);
      chk("rdpush_count", 32'(count), 32'd4);

      // count=2 with pop+push: count unchanged
      pop = 1'b1;
      step();
      step();
      chk("pp2_pre_count", 32'(count), 32'd2);
      in_valid = 1'b1; in_data = 4'hC;
      #1;
      chk("pp2_waddr", 32'(rf_waddr), 32'd2);
      step();
      idle();
      chk("pp2_count", 32'(count), 32'd2);
      rd_req = 1'b1; rd_offset = 2'd1;
      #1;
      chk("pp2_raddr", 32'(rf_raddr), 32'd2);
      step();
      idle();
      chk("pp2_data", 32'(out_data), 32'hC);

      // Reset while a read is in flight
      rd_req = 1'b1; rd_offset = 2'd0; rst = 1'b1;
      step();
      idle();
      chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
      chk("rst_mid_count", 32'(count), 32'd0);
      chk("rst_mid_in_ready", 32'(in_ready), 32'd0);
      rst = 1'b0;
      in_valid = 1'b1; in_data = 4'hD;
      #1;
      chk("rst_after_in_ready", 32'(in_ready), 32'd1);
      chk("rst_after_waddr", 32'(rf_waddr), 32'd0);
      chk("rst_after_wen", 32'(rf_wen), 32'd1);
      step();
      idle();
      chk("rst_after_count", 32'(count), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
